// File: rtl/jtkicker_arb_pkg.sv
// Shared types for the jtkicker VRAM arbiter: grant states and the
// width of the CPU starvation counter.
package jtkicker_arb_pkg;

  // IDLE: no access this cycle, GV: scanner owns the RAM, GC: CPU owns the RAM
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GV   = 2'd1,
    GC   = 2'd2
  } arb_state_e;

  // Width of the lost-cycle counter; wide enough for MAXWAIT up to 15
  localparam int WAIT_W = 4;

endpackage

// File: rtl/jtkicker_arb_starve.sv
// Starvation guard for the VRAM arbiter. Counts consecutive arbitration
// cycles the CPU lost to the scanner and raises force_cpu once MAXWAIT
// of them have piled up, so the CPU is guaranteed a slot.
module jtkicker_arb_starve
  import jtkicker_arb_pkg::*;
#(
  parameter int MAXWAIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_lose,
  input  logic cpu_win,
  output logic force_cpu
);

  logic [WAIT_W-1:0] wait_cnt;

  // Count lost cycles, clear on a CPU grant, hold at the MAXWAIT ceiling
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (cpu_win) begin
      wait_cnt <= '0;
    end else if (cpu_lose && (wait_cnt != WAIT_W'(MAXWAIT))) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Once the ceiling is reached the CPU wins the next contested cycle
  always_comb begin
    force_cpu = (wait_cnt == WAIT_W'(MAXWAIT));
  end

endmodule

// File: rtl/jtkicker_vram_arb.sv
// Two-requester arbiter for a single-port VRAM shared by the video
// scanner and the 6809. The grant is decided combinationally in the
// grant cycle and drives the RAM address/strobe directly; the state
// register remembers who was granted so the matching ok pulse and read
// data appear one cycle later, when the synchronous RAM returns data.
// Optional build macro: JTKICKER_ARB_STATS_EN adds the st_stall counter.
module jtkicker_vram_arb
  import jtkicker_arb_pkg::*;
#(
  parameter int AW      = 11,
  parameter int MAXWAIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_cs,
  input  logic          cpu_rnw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_ok,
  output logic          cpu_busy,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [7:0]    vid_rdata,
  output logic          vid_ok,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata,
  output logic [15:0]   st_stall
);

  arb_state_e  state_q;
  arb_state_e  state_d;
  logic        served;
  logic        cpu_inflight;
  logic        vid_pend;
  logic        cpu_pend;
  logic        grant_v;
  logic        grant_c;
  logic        force_cpu;
  logic        cpu_rd_q;
  logic [7:0]  vid_rdata_q;
  logic [7:0]  cpu_rdata_q;

  jtkicker_arb_starve #(
    .MAXWAIT (MAXWAIT)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .cpu_lose  (cpu_pend & grant_v),
    .cpu_win   (grant_c),
    .force_cpu (force_cpu)
  );

  // Pick this cycle's owner: video by default, CPU when alone or starved.
  // The scanner streams, so a held vid_req is a fresh read every cycle.
  always_comb begin
    state_d      = IDLE;
    cpu_inflight = (state_q == GC);
    vid_pend     = vid_req;
    cpu_pend     = cpu_cs & ~served & ~cpu_inflight;
    if (!rst) begin
      if (cpu_pend && (!vid_pend || force_cpu)) begin
        state_d = GC;
      end else if (vid_pend) begin
        state_d = GV;
      end
    end
    grant_v = (state_d == GV);
    grant_c = (state_d == GC);
  end

  // Grant register; its value is the access whose data returns this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Drive the RAM port for whichever requester holds the grant
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = 8'h00;
    if (grant_c) begin
      ram_addr = cpu_addr;
      if (!cpu_rnw) begin
        ram_we    = 1'b1;
        ram_wdata = cpu_wdata;
      end
    end else if (grant_v) begin
      ram_addr = vid_addr;
    end
  end

  // Remember whether the CPU access in flight is a read, and whether the
  // current CPU request has already been served (cleared when cs drops)
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rd_q <= 1'b0;
      served   <= 1'b0;
    end else begin
      cpu_rd_q <= grant_c & cpu_rnw;
      if (!cpu_cs) begin
        served <= 1'b0;
      end else if (grant_c) begin
        served <= 1'b1;
      end
    end
  end

  // Ok pulses and read data in the cycle after the grant; the data
  // registers hold the last value between accesses
  always_comb begin
    vid_ok    = (state_q == GV);
    cpu_ok    = (state_q == GC);
    vid_rdata = vid_ok ? ram_rdata : vid_rdata_q;
    cpu_rdata = (cpu_ok && cpu_rd_q) ? ram_rdata : cpu_rdata_q;
    cpu_busy  = cpu_cs & ~served;
  end

  // Capture returned read data so it stays valid after the ok pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      vid_rdata_q <= 8'h00;
      cpu_rdata_q <= 8'h00;
    end else begin
      vid_rdata_q <= vid_rdata;
      cpu_rdata_q <= cpu_rdata;
    end
  end

`ifdef JTKICKER_ARB_STATS_EN
  // Count the cycles the CPU is held off, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      st_stall <= 16'h0000;
    end else if (cpu_busy && (st_stall != 16'hFFFF)) begin
      st_stall <= st_stall + 16'd1;
    end
  end
`else
  assign st_stall = 16'h0000;
`endif

endmodule

// File: tb/tb_jtkicker_vram_arb.sv
// Directed bench for jtkicker_vram_arb with a synchronous 2Kx8 RAM model.
module tb_jtkicker_vram_arb;

  localparam int AW = 11;

  logic          clk;
  logic          rst;
  logic          cpu_cs;
  logic          cpu_rnw;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic [7:0]    cpu_rdata;
  logic          cpu_ok;
  logic          cpu_busy;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [7:0]    vid_rdata;
  logic          vid_ok;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;
  logic [15:0]   st_stall;

  logic [7:0]    mem [0:2047];
  int            checks;
  int            errors;

  jtkicker_vram_arb #(
    .AW      (AW),
    .MAXWAIT (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_cs    (cpu_cs),
    .cpu_rnw   (cpu_rnw),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ok    (cpu_ok),
    .cpu_busy  (cpu_busy),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_rdata (vid_rdata),
    .vid_ok    (vid_ok),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .st_stall  (st_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: write on strobe, registered read one cycle later
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic test_reset;
    rst = 1'b1;
    cpu_cs = 1'b0; cpu_rnw = 1'b1; cpu_addr = '0; cpu_wdata = 8'h00;
    vid_req = 1'b0; vid_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (cpu_ok !== 1'b0) begin errors++; $display("[TB] FAIL rst_cpu_ok: got %b expected 0", cpu_ok); end
    checks++; if (vid_ok !== 1'b0) begin errors++; $display("[TB] FAIL rst_vid_ok: got %b expected 0", vid_ok); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_ram_we: got %b expected 0", ram_we); end
    checks++; if (ram_addr !== 11'h000) begin errors++; $display("[TB] FAIL rst_ram_addr: got %h expected 000", ram_addr); end
    checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("[TB] FAIL rst_cpu_rdata: got %h expected 00", cpu_rdata); end
    checks++; if (vid_rdata !== 8'h00) begin errors++; $display("[TB] FAIL rst_vid_rdata: got %h expected 00", vid_rdata); end
    checks++; if (cpu_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_cpu_busy: got %b expected 0", cpu_busy); end
    checks++; if (st_stall !== 16'h0000) begin errors++; $display("[TB] FAIL rst_st_stall: got %h expected 0000", st_stall); end
  endtask

  task automatic test_vid_read;
    @(posedge clk); #1 vid_req = 1'b1; vid_addr = 11'h010;
    @(negedge clk);
    checks++; if (ram_addr !== 11'h010) begin errors++; $display("[TB] FAIL vid_grant_addr: got %h expected 010", ram_addr); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL vid_grant_we: got %b expected 0", ram_we); end
    checks++; if (vid_ok !== 1'b0) begin errors++; $display("[TB] FAIL vid_early_ok: got %b expected 0", vid_ok); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (vid_ok !== 1'b1) begin errors++; $display("[TB] FAIL vid_ok: got %b expected 1", vid_ok); end
    checks++; if (vid_rdata !== 8'hA5) begin errors++; $display("[TB] FAIL vid_rdata: got %h expected a5", vid_rdata); end
    vid_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (vid_ok !== 1'b0) begin errors++; $display("[TB] FAIL vid_ok_single: got %b expected 0", vid_ok); end
    checks++; if (vid_rdata !== 8'hA5) begin errors++; $display("[TB] FAIL vid_rdata_hold: got %h expected a5", vid_rdata); end
  endtask

  task automatic test_cpu_write;
    @(posedge clk); #1 cpu_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = 11'h123; cpu_wdata = 8'h3C;
    @(negedge clk);
    checks++; if (cpu_busy !== 1'b1) begin errors++; $display("[TB] FAIL wr_busy_g: got %b expected 1", cpu_busy); end
    checks++; if (ram_we !== 1'b1) begin errors++; $display("[TB] FAIL wr_we_g: got %b expected 1", ram_we); end
    checks++; if (ram_addr !== 11'h123) begin errors++; $display("[TB] FAIL wr_addr_g: got %h expected 123", ram_addr); end
    checks++; if (ram_wdata !== 8'h3C) begin errors++; $display("[TB] FAIL wr_wdata_g: got %h expected 3c", ram_wdata); end
    checks++; if (cpu_ok !== 1'b0) begin errors++; $display("[TB] FAIL wr_ok_g: got %b expected 0", cpu_ok); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (cpu_ok !== 1'b1) begin errors++; $display("[TB] FAIL wr_ok_g1: got %b expected 1", cpu_ok); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL wr_we_g1: got %b expected 0", ram_we); end
    checks++; if (cpu_busy !== 1'b0) begin errors++; $display("[TB] FAIL wr_busy_g1: got %b expected 0", cpu_busy); end
    checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("[TB] FAIL wr_rdata_kept: got %h expected 00", cpu_rdata); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (cpu_busy !== 1'b0) begin errors++; $display("[TB] FAIL wr_busy_held: got %b expected 0", cpu_busy); end
    checks++; if (cpu_ok !== 1'b0) begin errors++; $display("[TB] FAIL wr_ok_again: got %b expected 0", cpu_ok); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL wr_we_again: got %b expected 0", ram_we); end
    cpu_cs = 1'b0;
    @(posedge clk); #1 cpu_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = 11'h123;
    @(negedge clk);
    checks++; if (ram_addr !== 11'h123) begin errors++; $display("[TB] FAIL rb_addr: got %h expected 123", ram_addr); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL rb_we: got %b expected 0", ram_we); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (cpu_ok !== 1'b1) begin errors++; $display("[TB] FAIL rb_ok: got %b expected 1", cpu_ok); end
    checks++; if (cpu_rdata !== 8'h3C) begin errors++; $display("[TB] FAIL rb_rdata: got %h expected 3c", cpu_rdata); end
    cpu_cs = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_withdraw;
    @(posedge clk); #1
    vid_req = 1'b1; vid_addr = 11'h300;
    cpu_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = 11'h155; cpu_wdata = 8'h77;
    @(negedge clk);
    checks++; if (ram_addr !== 11'h300) begin errors++; $display("[TB] FAIL wd_vid_wins: got %h expected 300", ram_addr); end
    checks++; if (cpu_busy !== 1'b1) begin errors++; $display("[TB] FAIL wd_busy: got %b expected 1", cpu_busy); end
    cpu_cs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (cpu_ok !== 1'b0) begin errors++; $display("[TB] FAIL wd_no_ok cycle %0d: got %b expected 0", i, cpu_ok); end
      checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL wd_no_we cycle %0d: got %b expected 0", i, ram_we); end
      checks++; if (ram_addr !== 11'h300) begin errors++; $display("[TB] FAIL wd_addr cycle %0d: got %h expected 300", i, ram_addr); end
    end
    vid_req = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem[11'h155] !== 8'h00) begin errors++; $display("[TB] FAIL wd_mem_untouched: got %h expected 00", mem[11'h155]); end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1 vid_req = 1'b1; vid_addr = 11'h010;
    @(negedge clk);
    checks++; if (ram_addr !== 11'h010) begin errors++; $display("[TB] FAIL rm_grant: got %h expected 010", ram_addr); end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; vid_req = 1'b0;
    @(negedge clk);
    checks++; if (vid_ok !== 1'b0) begin errors++; $display("[TB] FAIL rm_no_ok: got %b expected 0", vid_ok); end
    checks++; if (vid_rdata !== 8'h00) begin errors++; $display("[TB] FAIL rm_vid_rdata: got %h expected 00", vid_rdata); end
    checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("[TB] FAIL rm_cpu_rdata: got %h expected 00", cpu_rdata); end
    checks++; if (ram_addr !== 11'h000) begin errors++; $display("[TB] FAIL rm_ram_addr: got %h expected 000", ram_addr); end
    @(posedge clk); #1 cpu_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = 11'h123;
    @(negedge clk);
    checks++; if (ram_addr !== 11'h123) begin errors++; $display("[TB] FAIL rm_next_addr: got %h expected 123", ram_addr); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (cpu_ok !== 1'b1) begin errors++; $display("[TB] FAIL rm_next_ok: got %b expected 1", cpu_ok); end
    checks++; if (cpu_rdata !== 8'h3C) begin errors++; $display("[TB] FAIL rm_next_rdata: got %h expected 3c", cpu_rdata); end
    cpu_cs = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_starvation;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    cpu_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = 11'h010;
    vid_req = 1'b1; vid_addr = 11'h200;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      @(negedge clk);
      checks++; if (cpu_busy !== 1'b1) begin errors++; $display("[TB] FAIL sv_busy cycle %0d: got %b expected 1", i, cpu_busy); end
      checks++; if (dut.u_starve.wait_cnt !== 4'(i)) begin errors++; $display("[TB] FAIL sv_wait cycle %0d: got %0d expected %0d", i, dut.u_starve.wait_cnt, i); end
      if (i < 3) begin
        checks++; if (ram_addr !== 11'h200) begin errors++; $display("[TB] FAIL sv_vid_grant cycle %0d: got %h expected 200", i, ram_addr); end
      end else begin
        checks++; if (ram_addr !== 11'h010) begin errors++; $display("[TB] FAIL sv_cpu_grant: got %h expected 010", ram_addr); end
      end
      if (i == 1) begin
        checks++; if (vid_rdata !== 8'h5A) begin errors++; $display("[TB] FAIL sv_vid_rdata: got %h expected 5a", vid_rdata); end
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (cpu_ok !== 1'b1) begin errors++; $display("[TB] FAIL sv_cpu_ok: got %b expected 1", cpu_ok); end
    checks++; if (cpu_rdata !== 8'hA5) begin errors++; $display("[TB] FAIL sv_cpu_rdata: got %h expected a5", cpu_rdata); end
    checks++; if (dut.u_starve.wait_cnt !== 4'd0) begin errors++; $display("[TB] FAIL sv_wait_clear: got %0d expected 0", dut.u_starve.wait_cnt); end
    checks++; if (ram_addr !== 11'h200) begin errors++; $display("[TB] FAIL sv_vid_resumes: got %h expected 200", ram_addr); end
`ifdef JTKICKER_ARB_STATS_EN
    checks++; if (st_stall !== 16'd4) begin errors++; $display("[TB] FAIL sv_st_stall: got %0d expected 4", st_stall); end
`else
    checks++; if (st_stall !== 16'd0) begin errors++; $display("[TB] FAIL sv_st_stall: got %0d expected 0", st_stall); end
`endif
    cpu_cs = 1'b0; vid_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[11'h010] = 8'hA5;
    mem[11'h200] = 8'h5A;
    ram_rdata = 8'h00;
    $display("[TB] start");
    test_reset();
    test_vid_read();
    test_cpu_write();
    test_withdraw();
    test_reset_mid();
    test_starvation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
